tff_mode_reg: RTL and testbench
===============================

Name: tff_mode_reg

Overview:
- Parametrised WIDTH-bit register built only from T flip-flops: every bit updates as q <= q ^ t[i].
- Each cycle a per-bit toggle vector is computed from the selected mode.
- Modes: hold, parallel load (D behaviour), masked toggle, and synchronous up/down count.
- Serves as the common storage/counter primitive for control and datapath blocks that need D-style loads and counting from one T-based cell.

Parameters:
- WIDTH, 8, register width in bits (legal range 2..32).
- RST_VAL, 0, value loaded into q on reset (WIDTH bits).

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  asynchronous active-low reset.
- en  input  1  update enable; when low the register holds.
- clr  input  1  synchronous clear to 0; overrides en and mode.
- mode  input  2  00 hold, 01 load, 10 toggle-mask, 11 count.
- dir  input  1  count direction: 1 up, 0 down (used only in mode 11).
- d  input  WIDTH  load data (mode 01) or toggle mask (mode 10).
- q  output  WIDTH  register state.
- qbar  output  WIDTH  bitwise complement of q.
- tc  output  1  terminal count, combinational.
- wrap  output  1  registered one-cycle pulse after a count wrap.

Behaviour:
- Reset: rstn low forces q=RST_VAL, qbar=~RST_VAL, wrap=0 immediately (asynchronous). Release is synchronous to the next rising edge.
- qbar is a registered complement of q: it is updated on the same edge and is never skewed from q.
- Toggle vector t (WIDTH bits), in priority order:
  - clr=1: t = q, so the next q is 0.
  - en=0: t = 0 (hold).
  - mode 00: t = 0.
  - mode 01: t = q ^ d, so the next q is d.
  - mode 10: t = d, so bits flip where d=1.
  - mode 11, dir=1: t[0]=1; t[i] = AND of q[i-1:0].
  - mode 11, dir=0: t[0]=1; t[i] = AND of ~q[i-1:0].
- Latency: one clock from input to q for every mode; there is no bypass path.
- Count arithmetic is modulo 2^WIDTH. Up from all-ones goes to 0; down from 0 goes to all-ones.
- tc = en & ~clr & (mode==11) & (dir ? q==all-ones : q==0). It is high in the cycle whose edge wraps.
- wrap is registered from tc, so it is high for exactly the one cycle after the wrapping edge. clr or en=0 in the tc cycle suppresses it.
- Mode or dir changes take effect on the very next edge; count history carries no state.
- Reset asserted mid-count aborts immediately; wrap clears even if pending.
- X on mode while en=1 is illegal. Verification flags it with an assertion.

Optional Feature:
- Macro: TFF_MODE_REG_SAT_EN.
- Defined: mode 11 saturates. With dir=1 at all-ones, t=0. With dir=0 at 0, t=0. tc still asserts at the boundary, but wrap never asserts (it is tied low, and its register is removed).
- Undefined: modulo wrap as described above, and wrap is active.

Test Plan:
- rstn=0 asynchronously mid-cycle with RST_VAL=8'hA5 -> q=A5 and qbar=5A before the next edge; wrap=0.
- mode 01, en=1, d=3C then C3 on consecutive edges -> q=3C then C3. en=0 with d=FF -> q stays C3.
- mode 10, q=F0, d=0F then 81 -> q=FF then 7E; qbar always equals ~q.
- mode 11, dir=1, starting at FE -> q FE, FF, 00, 01. tc high while q=FF. wrap high for exactly the cycle with q=00.
  - With TFF_MODE_REG_SAT_EN defined -> q FE, FF, FF, FF and wrap never asserts.
- mode 11, dir=0, starting at 01 -> 00 then FF; wrap pulses once. Flip dir=1 at q=FF -> q returns to 00 with a second wrap pulse.
- clr=1 together with en=1, mode 01, d=55 -> q=00 on the next edge. clr asserted in a tc cycle -> q=00, wrap stays 0.

Source files
------------

// File: rtl/tff_mode_reg.sv
// WIDTH-bit register built from T flip-flops, with hold/load/toggle-mask/count modes.
// Optional build macro TFF_MODE_REG_SAT_EN: counting saturates and wrap is tied low.
module tff_mode_reg #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             clr,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc,
  output logic             wrap
);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] qbar_r;
  logic [WIDTH-1:0] cnt_t_s;
  logic [WIDTH-1:0] t_s;
  logic [WIDTH-1:0] q_nxt_s;
  logic             at_end_s;
  logic             tc_s;

  assign at_end_s = dir ? (&q_r) : ~(|q_r);
  assign tc_s     = en & ~clr & (mode == 2'b11) & at_end_s;
  assign q_nxt_s  = q_r ^ t_s;

  // Counter toggles: bit i flips when all lower bits are at the carry/borrow value
  always_comb begin : cnt_toggle
    logic carry_v;
    cnt_t_s = {WIDTH{1'b0}};
    carry_v = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_t_s[i] = carry_v;
      carry_v    = carry_v & (dir ? q_r[i] : ~q_r[i]);
    end
`ifdef TFF_MODE_REG_SAT_EN
    if (at_end_s) begin
      cnt_t_s = {WIDTH{1'b0}};
    end else begin
      cnt_t_s = cnt_t_s;
    end
`endif
  end

  // Toggle vector selection in priority order: clear, enable, mode
  always_comb begin
    t_s = {WIDTH{1'b0}};
    if (clr) begin
      t_s = q_r;
    end else if (!en) begin
      t_s = {WIDTH{1'b0}};
    end else begin
      case (mode)
        2'b00:   t_s = {WIDTH{1'b0}};
        2'b01:   t_s = q_r ^ d;
        2'b10:   t_s = d;
        2'b11:   t_s = cnt_t_s;
        default: t_s = {WIDTH{1'b0}};
      endcase
    end
  end

  // T flip-flop storage; complement is registered alongside so it never skews from q
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q_r    <= RST_VAL;
      qbar_r <= ~RST_VAL;
    end else begin
      q_r    <= q_nxt_s;
      qbar_r <= ~q_nxt_s;
    end
  end

`ifdef TFF_MODE_REG_SAT_EN
  assign wrap = 1'b0;
`else
  logic wrap_r;

  // One-cycle pulse following the edge on which the count wrapped
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wrap_r <= 1'b0;
    end else begin
      wrap_r <= tc_s;
    end
  end

  assign wrap = wrap_r;
`endif

  assign q    = q_r;
  assign qbar = qbar_r;
  assign tc   = tc_s;

  tff_mode_reg_chk u_chk (
    .clk  (clk),
    .rstn (rstn),
    .en   (en),
    .mode (mode)
  );

endmodule

// Protocol checker: mode must be known whenever the register is enabled.
module tff_mode_reg_chk (
  input logic       clk,
  input logic       rstn,
  input logic       en,
  input logic [1:0] mode
);

  a_mode_known: assert property (@(posedge clk) disable iff (!rstn) en |-> !$isunknown(mode));

endmodule

// File: tb/tb_tff_mode_reg.sv
// Scoreboard bench for tff_mode_reg (WIDTH=8, RST_VAL=8'hA5) with a behavioural model.
module tb_tff_mode_reg;

  logic       clk;
  logic       rstn;
  logic       en;
  logic       clr;
  logic [1:0] mode;
  logic       dir;
  logic [7:0] d;
  logic [7:0] q;
  logic [7:0] qbar;
  logic       tc;
  logic       wrap;

  typedef struct {
    logic [7:0] q;
    logic [7:0] qbar;
    logic       wrap;
    logic       tc;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [7:0] m_q;
  logic       m_wrap;

`ifdef TFF_MODE_REG_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  tff_mode_reg #(.WIDTH(8), .RST_VAL(8'hA5)) dut (
    .clk  (clk),
    .rstn (rstn),
    .en   (en),
    .clr  (clr),
    .mode (mode),
    .dir  (dir),
    .d    (d),
    .q    (q),
    .qbar (qbar),
    .tc   (tc),
    .wrap (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: just before each rising edge, compare outputs against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("q",    32'(q),    32'(e.q));
        chk("qbar", 32'(qbar), 32'(e.qbar));
        chk("wrap", 32'(wrap), 32'(e.wrap));
        chk("tc",   32'(tc),   32'(e.tc));
      end
    end
  end

  function automatic exp_t cur_exp(input logic tcv);
    exp_t e;
    e.q    = m_q;
    e.qbar = ~m_q;
    e.wrap = m_wrap;
    e.tc   = tcv;
    return e;
  endfunction

  // One cycle of stimulus: drive inputs, record expected outputs, advance the model
  task automatic step(input bit e_i, input bit c_i, input logic [1:0] md, input bit dr, input logic [7:0] dd);
    logic [8:0] sum;
    logic [7:0] nq;
    logic       ovf;
    logic       tcv;
    @(negedge clk);
    rstn = 1'b1; en = e_i; clr = c_i; mode = md; dir = dr; d = dd;
    tcv = e_i && !c_i && md == 2'd3 && (dr ? (m_q == 8'd255) : (m_q == 8'd0));
    sbq.push_back(cur_exp(tcv));
    ovf = 1'b0;
    if (c_i) nq = 8'd0;
    else if (!e_i) nq = m_q;
    else begin
      case (md)
        2'd0: nq = m_q;
        2'd1: nq = dd;
        2'd2: nq = m_q ^ dd;
        default: begin
          sum = dr ? ({1'b0, m_q} + 9'd1) : ({1'b0, m_q} - 9'd1);
          ovf = sum[8];
          nq  = (SAT && ovf) ? m_q : sum[7:0];
        end
      endcase
    end
    m_wrap = ovf && !SAT;
    m_q    = nq;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must change before the next edge
  task automatic reset_mid;
    @(negedge clk);
    #1;
    en = 1'b0; clr = 1'b0;
    rstn = 1'b0;
    m_q = 8'hA5;
    m_wrap = 1'b0;
    sbq.push_back(cur_exp(1'b0));
  endtask

  initial begin
    rstn = 1'b0; en = 1'b0; clr = 1'b0; mode = 2'd0; dir = 1'b0; d = 8'h00;
    m_q = 8'hA5; m_wrap = 1'b0;
    repeat (2) @(negedge clk);

    // reset value check, then load sequence and hold
    reset_mid();
    step(1, 0, 2'd1, 0, 8'h3C);
    step(1, 0, 2'd1, 0, 8'hC3);
    step(0, 0, 2'd1, 0, 8'hFF);
    step(0, 0, 2'd0, 0, 8'h00);
    // masked toggle
    step(1, 0, 2'd1, 0, 8'hF0);
    step(1, 0, 2'd2, 0, 8'h0F);
    step(1, 0, 2'd2, 0, 8'h81);
    step(0, 0, 2'd0, 0, 8'h00);
    // count up across the top
    step(1, 0, 2'd1, 0, 8'hFE);
    repeat (4) step(1, 0, 2'd3, 1, 8'h00);
    step(0, 0, 2'd0, 0, 8'h00);
    // count down across zero, then reverse direction at FF
    step(1, 0, 2'd1, 0, 8'h01);
    repeat (2) step(1, 0, 2'd3, 0, 8'h00);
    repeat (2) step(1, 0, 2'd3, 1, 8'h00);
    step(0, 0, 2'd0, 0, 8'h00);
    // clear overrides a load, and suppresses wrap in a tc cycle
    step(1, 0, 2'd1, 0, 8'hAA);
    step(1, 1, 2'd1, 0, 8'h55);
    step(1, 0, 2'd1, 0, 8'hFF);
    step(1, 1, 2'd3, 1, 8'h00);
    step(0, 0, 2'd0, 0, 8'h00);
    // reset while a wrap pulse is showing
    step(1, 0, 2'd1, 0, 8'hFF);
    step(1, 0, 2'd3, 1, 8'h00);
    reset_mid();
    step(0, 0, 2'd0, 0, 8'h00);

    // randomized traffic, biased toward counting and boundary loads
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [1:0] md;
      logic [7:0] dd;
      r  = int'($urandom_range(0, 5));
      md = (r > 3) ? 2'd3 : 2'(r);
      dd = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00) : 8'($urandom);
      if ($urandom_range(0, 59) == 0) reset_mid();
      else step($urandom_range(0, 7) != 0, $urandom_range(0, 19) == 0, md, 1'($urandom_range(0, 1)), dd);
    end
    step(0, 0, 2'd0, 0, 8'h00);

    for (int i = 0; i < 10 && sbq.size() != 0; i++) @(negedge clk);
    if (sbq.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
    end
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
